// File: rtl/cnn_cls_pkg.sv
// cnn_cls_pkg: shared FSM states, slot type and default sizes for the classifier back end
package cnn_cls_pkg;
   localparam int DEF_ACC_WIDTH = 24;
   localparam int DEF_IN_SIZE = 10;
   localparam int DEF_TOP_K = 3;
   localparam int DEF_IDX_W = $clog2(DEF_IN_SIZE);
   typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
   typedef struct packed {
      logic valid;
      logic [DEF_IDX_W-1:0] idx;
      logic signed [DEF_ACC_WIDTH-1:0] logit;
   } slot_t;
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/argmax_topk_if.sv
// argmax_topk_if: logit stream in, ranked results out; m_margin exists only with ARGMAX_TOPK_MARGIN_EN
interface argmax_topk_if #(
   parameter int ACC_WIDTH = cnn_cls_pkg::DEF_ACC_WIDTH,
   parameter int IN_SIZE = cnn_cls_pkg::DEF_IN_SIZE,
   parameter int TOP_K = cnn_cls_pkg::DEF_TOP_K
);
   localparam int IDX_W = cnn_cls_pkg::idx_w(IN_SIZE);
   localparam int RANK_W = cnn_cls_pkg::idx_w(TOP_K);
   logic start, busy, s_valid, s_ready, m_valid, m_ready, m_last;
   logic signed [ACC_WIDTH-1:0] s_logit, m_logit;
   logic [RANK_W-1:0] m_rank;
   logic [IDX_W-1:0] m_class_idx;
`ifdef ARGMAX_TOPK_MARGIN_EN
   logic [ACC_WIDTH-1:0] m_margin;
   modport slave (input start, s_valid, s_logit, m_ready,
                  output busy, s_ready, m_valid, m_rank, m_class_idx, m_logit, m_last, m_margin);
   modport master (output start, s_valid, s_logit, m_ready,
                   input busy, s_ready, m_valid, m_rank, m_class_idx, m_logit, m_last, m_margin);
`else
   modport slave (input start, s_valid, s_logit, m_ready,
                  output busy, s_ready, m_valid, m_rank, m_class_idx, m_logit, m_last);
   modport master (output start, s_valid, s_logit, m_ready,
                   input busy, s_ready, m_valid, m_rank, m_class_idx, m_logit, m_last);
`endif
endinterface

// File: rtl/topk_slot.sv
// topk_slot: one rank of the sorted insertion chain; takes the new logit, shifts in the upper entry, or holds
module topk_slot import cnn_cls_pkg::*; #(
   parameter type slot_w_t = slot_t
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    clear,
   input  logic    en,
   input  logic    upper_moved,
   input  slot_w_t new_s,
   input  slot_w_t upper_s,
   output slot_w_t slot_q,
   output logic    moved
);
   slot_w_t slot_d;
   logic take_new;
   always_comb begin
      take_new = en && !upper_moved && (!slot_q.valid || $signed(new_s.logit) > $signed(slot_q.logit));
      moved = take_new || (en && upper_moved);
      slot_d = clear ? '0 : (en && upper_moved) ? upper_s : take_new ? new_s : slot_q;
   end
   always_ff @(posedge clk)
      slot_q <= reset ? '0 : slot_d;
endmodule

// File: rtl/argmax_topk.sv
// argmax_topk: streaming top-K argmax over a frame of signed logits
// ARGMAX_TOPK_MARGIN_EN adds m_margin = slot0 - slot1, saturated
module argmax_topk import cnn_cls_pkg::*; #(
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int IN_SIZE = DEF_IN_SIZE,
   parameter int TOP_K = DEF_TOP_K
) (
   input logic clk,
   input logic reset,
   argmax_topk_if.slave bus
);
   localparam int IDX_W = idx_w(IN_SIZE);
   localparam int RANK_W = idx_w(TOP_K);
   typedef struct packed {
      logic valid;
      logic [IDX_W-1:0] idx;
      logic signed [ACC_WIDTH-1:0] logit;
   } frame_slot_t;
   if (IN_SIZE < 2 || TOP_K < 1 || TOP_K > IN_SIZE) begin : g_bad_cfg
      $error("argmax_topk: need IN_SIZE >= 2 and 1 <= TOP_K <= IN_SIZE");
   end
   state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [RANK_W-1:0] rank_q, rank_d;
   logic clear, accept;
   frame_slot_t new_s;
   frame_slot_t slots [TOP_K];
   logic moved [TOP_K];
   assign new_s = {1'b1, idx_q, bus.s_logit};
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      rank_d = rank_q;
      clear = 1'b0;
      accept = 1'b0;
      unique case (state_q)
         IDLE: if (bus.start) begin
            state_d = SCAN;
            idx_d = '0;
            rank_d = '0;
            clear = 1'b1;
         end
         SCAN: if (bus.s_valid) begin
            accept = 1'b1;
            idx_d = idx_q + IDX_W'(1);
            state_d = (idx_q == IDX_W'(IN_SIZE - 1)) ? EMIT : SCAN;
         end
         EMIT: if (bus.m_ready) begin
            state_d = (rank_q == RANK_W'(TOP_K - 1)) ? IDLE : EMIT;
            rank_d = (rank_q == RANK_W'(TOP_K - 1)) ? '0 : rank_q + RANK_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q <= '0;
         rank_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         rank_q <= rank_d;
      end
   end
   // slot 0 holds the largest logit; a take or shift ripples down the chain
   for (genvar g = 0; g < TOP_K; g++) begin : g_slot
      if (g == 0) begin : g_head
         topk_slot #(.slot_w_t(frame_slot_t)) u_slot (
            .clk, .reset, .clear, .en(accept), .upper_moved(1'b0), .new_s,
            .upper_s('0), .slot_q(slots[g]), .moved(moved[g]));
      end else begin : g_tail
         topk_slot #(.slot_w_t(frame_slot_t)) u_slot (
            .clk, .reset, .clear, .en(accept), .upper_moved(moved[g-1]), .new_s,
            .upper_s(slots[g-1]), .slot_q(slots[g]), .moved(moved[g]));
      end
   end
   assign bus.busy = state_q != IDLE;
   assign bus.s_ready = state_q == SCAN;
   assign bus.m_valid = state_q == EMIT;
   assign bus.m_last = (state_q == EMIT) && (rank_q == RANK_W'(TOP_K - 1));
   assign bus.m_rank = rank_q;
   assign bus.m_class_idx = slots[rank_q].idx;
   assign bus.m_logit = slots[rank_q].logit;
`ifdef ARGMAX_TOPK_MARGIN_EN
   if (TOP_K == 1) begin : g_margin_none
      assign bus.m_margin = '0;
   end else begin : g_margin
      logic signed [ACC_WIDTH:0] diff;
      assign diff = {slots[0].logit[ACC_WIDTH-1], slots[0].logit} - {slots[1].logit[ACC_WIDTH-1], slots[1].logit};
      assign bus.m_margin = diff[ACC_WIDTH] ? '1 : diff[ACC_WIDTH-1:0];
   end
`else
`endif
endmodule

// File: tb/tb_argmax_topk.sv
// tb_argmax_topk: directed checks of ranking, ties, stalls, aborts and ignored starts
module tb_argmax_topk;
   typedef int frame_t [10];
   logic clk = 1'b0;
   logic reset;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;

   argmax_topk_if #(.ACC_WIDTH(24), .IN_SIZE(10), .TOP_K(3)) a_if ();
   argmax_topk #(.ACC_WIDTH(24), .IN_SIZE(10), .TOP_K(3)) dut (.clk(clk), .reset(reset), .bus(a_if.slave));
   argmax_topk_if #(.ACC_WIDTH(24), .IN_SIZE(2), .TOP_K(1)) b_if ();
   argmax_topk #(.ACC_WIDTH(24), .IN_SIZE(2), .TOP_K(1)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));
`ifdef ARGMAX_TOPK_MARGIN_EN
   argmax_topk_if #(.ACC_WIDTH(8), .IN_SIZE(10), .TOP_K(3)) c_if ();
   argmax_topk #(.ACC_WIDTH(8), .IN_SIZE(10), .TOP_K(3)) dut_c (.clk(clk), .reset(reset), .bus(c_if.slave));
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input frame_t v, input bit gaps, input bit start_in_scan);
      a_if.start = 1'b1;
      tick();
      a_if.start = start_in_scan;
      for (int i = 0; i < 10; i++) begin
         a_if.s_valid = 1'b1;
         a_if.s_logit = 24'(v[i]);
         tick();
         a_if.s_valid = 1'b0;
         if (gaps && i < 9) begin
            a_if.s_logit = 24'sh7fffff;
            tick();
            tick();
         end
      end
      a_if.start = 1'b0;
   endtask

   task automatic test_reset;
      total++;
      if (a_if.busy !== 1'b0 || a_if.s_ready !== 1'b0 || a_if.m_valid !== 1'b0 || a_if.m_last !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: busy=%b s_ready=%b m_valid=%b m_last=%b, want all 0",
                  a_if.busy, a_if.s_ready, a_if.m_valid, a_if.m_last);
      end
      total++;
      if (a_if.m_rank !== 2'd0 || a_if.m_class_idx !== 4'd0 || a_if.m_logit !== 24'sd0) begin
         bad++;
         $display("FAIL reset_data: rank=%0d idx=%0d logit=%0d, want 0 0 0", a_if.m_rank, a_if.m_class_idx, a_if.m_logit);
      end
`ifdef ARGMAX_TOPK_MARGIN_EN
      total++;
      if (a_if.m_margin !== 24'd0) begin
         bad++;
         $display("FAIL reset_margin: got %0d want 0", a_if.m_margin);
      end
`endif
   endtask

   task automatic test_basic;
      int ei [3] = '{2, 4, 8};
      int ev [3] = '{12, 12, 9};
      drive_frame('{5, -3, 12, 7, 12, 0, -8, 1, 9, 2}, 1'b0, 1'b0);
      a_if.m_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         total++;
         if (a_if.m_valid !== 1'b1 || a_if.m_rank !== 2'(r) || a_if.m_class_idx !== 4'(ei[r]) ||
             a_if.m_logit !== 24'(ev[r]) || a_if.m_last !== 1'(r == 2)) begin
            bad++;
            $display("FAIL basic_rank%0d: got v=%b rank=%0d idx=%0d logit=%0d last=%b, want v=1 idx=%0d logit=%0d last=%b",
                     r, a_if.m_valid, a_if.m_rank, a_if.m_class_idx, a_if.m_logit, a_if.m_last, ei[r], ev[r], r == 2);
         end
`ifdef ARGMAX_TOPK_MARGIN_EN
         total++;
         if (a_if.m_margin !== 24'd0) begin
            bad++;
            $display("FAIL basic_margin%0d: got %0d want 0", r, a_if.m_margin);
         end
`endif
         tick();
      end
      a_if.m_ready = 1'b0;
      total++;
      if (a_if.m_valid !== 1'b0 || a_if.busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_done: m_valid=%b busy=%b, want 0 0", a_if.m_valid, a_if.busy);
      end
   endtask

   task automatic test_most_negative;
      frame_t v;
      foreach (v[i]) v[i] = -8388608;
      drive_frame(v, 1'b0, 1'b0);
      a_if.m_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         total++;
         if (a_if.m_valid !== 1'b1 || a_if.m_class_idx !== 4'(r) || a_if.m_logit !== -24'sd8388608) begin
            bad++;
            $display("FAIL minneg_rank%0d: got v=%b idx=%0d logit=%0d, want v=1 idx=%0d logit=-8388608",
                     r, a_if.m_valid, a_if.m_class_idx, a_if.m_logit, r);
         end
         tick();
      end
      a_if.m_ready = 1'b0;
   endtask

   task automatic test_stall_gaps;
      int ei [3] = '{2, 4, 8};
      int ev [3] = '{12, 12, 9};
      drive_frame('{5, -3, 12, 7, 12, 0, -8, 1, 9, 2}, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (a_if.m_valid !== 1'b1 || a_if.m_rank !== 2'd0 || a_if.m_class_idx !== 4'd2 || a_if.m_logit !== 24'sd12) begin
            bad++;
            $display("FAIL stall_cycle%0d: got v=%b rank=%0d idx=%0d logit=%0d, want v=1 rank=0 idx=2 logit=12",
                     c, a_if.m_valid, a_if.m_rank, a_if.m_class_idx, a_if.m_logit);
         end
         tick();
      end
      a_if.m_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         total++;
         if (a_if.m_rank !== 2'(r) || a_if.m_class_idx !== 4'(ei[r]) || a_if.m_logit !== 24'(ev[r])) begin
            bad++;
            $display("FAIL gaps_rank%0d: got rank=%0d idx=%0d logit=%0d, want idx=%0d logit=%0d",
                     r, a_if.m_rank, a_if.m_class_idx, a_if.m_logit, ei[r], ev[r]);
         end
         tick();
      end
      a_if.m_ready = 1'b0;
   endtask

   task automatic test_reset_abort;
      int ei [3] = '{9, 8, 7};
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      a_if.s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_if.s_logit = 24'(100 + i);
         tick();
      end
      a_if.s_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (a_if.m_valid !== 1'b0 || a_if.busy !== 1'b0 || a_if.m_class_idx !== 4'd0 || a_if.m_logit !== 24'sd0) begin
            bad++;
            $display("FAIL abort_idle%0d: got v=%b busy=%b idx=%0d logit=%0d, want 0 0 0 0",
                     c, a_if.m_valid, a_if.busy, a_if.m_class_idx, a_if.m_logit);
         end
         tick();
      end
      drive_frame('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 1'b0, 1'b0);
      a_if.m_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         total++;
         if (a_if.m_valid !== 1'b1 || a_if.m_class_idx !== 4'(ei[r]) || a_if.m_logit !== 24'(ei[r] + 1)) begin
            bad++;
            $display("FAIL abort_rank%0d: got v=%b idx=%0d logit=%0d, want v=1 idx=%0d logit=%0d",
                     r, a_if.m_valid, a_if.m_class_idx, a_if.m_logit, ei[r], ei[r] + 1);
         end
         tick();
      end
      a_if.m_ready = 1'b0;
   endtask

   task automatic test_start_ignored;
      int ei [3] = '{2, 4, 8};
      drive_frame('{5, -3, 12, 7, 12, 0, -8, 1, 9, 2}, 1'b0, 1'b1);
      a_if.start = 1'b1;
      for (int c = 0; c < 2; c++) begin
         total++;
         if (a_if.m_valid !== 1'b1 || a_if.m_rank !== 2'd0 || a_if.m_class_idx !== 4'd2) begin
            bad++;
            $display("FAIL start_emit%0d: got v=%b rank=%0d idx=%0d, want v=1 rank=0 idx=2",
                     c, a_if.m_valid, a_if.m_rank, a_if.m_class_idx);
         end
         tick();
      end
      a_if.start = 1'b0;
      a_if.m_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         total++;
         if (a_if.m_rank !== 2'(r) || a_if.m_class_idx !== 4'(ei[r])) begin
            bad++;
            $display("FAIL start_rank%0d: got rank=%0d idx=%0d, want idx=%0d", r, a_if.m_rank, a_if.m_class_idx, ei[r]);
         end
         a_if.start = 1'(r == 2);
         tick();
      end
      a_if.start = 1'b0;
      a_if.m_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         total++;
         if (a_if.busy !== 1'b0 || a_if.m_valid !== 1'b0 || a_if.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_final%0d: got busy=%b v=%b s_ready=%b, want 0 0 0", c, a_if.busy, a_if.m_valid, a_if.s_ready);
         end
         tick();
      end
   endtask

   task automatic test_topk1;
      b_if.start = 1'b1;
      tick();
      b_if.start = 1'b0;
      b_if.s_valid = 1'b1;
      b_if.s_logit = 24'sd3;
      tick();
      b_if.s_logit = 24'sd4;
      tick();
      b_if.s_valid = 1'b0;
      total++;
      if (b_if.m_valid !== 1'b1 || b_if.m_rank !== 1'b0 || b_if.m_class_idx !== 1'b1 ||
          b_if.m_logit !== 24'sd4 || b_if.m_last !== 1'b1) begin
         bad++;
         $display("FAIL topk1_result: got v=%b rank=%0d idx=%0d logit=%0d last=%b, want 1 0 1 4 1",
                  b_if.m_valid, b_if.m_rank, b_if.m_class_idx, b_if.m_logit, b_if.m_last);
      end
`ifdef ARGMAX_TOPK_MARGIN_EN
      total++;
      if (b_if.m_margin !== 24'd0) begin
         bad++;
         $display("FAIL topk1_margin: got %0d want 0", b_if.m_margin);
      end
`endif
      b_if.m_ready = 1'b1;
      tick();
      b_if.m_ready = 1'b0;
      total++;
      if (b_if.m_valid !== 1'b0 || b_if.busy !== 1'b0) begin
         bad++;
         $display("FAIL topk1_done: got v=%b busy=%b, want 0 0", b_if.m_valid, b_if.busy);
      end
   endtask

`ifdef ARGMAX_TOPK_MARGIN_EN
   task automatic test_margin;
      int ev [3] = '{127, -128, -128};
      c_if.start = 1'b1;
      tick();
      c_if.start = 1'b0;
      c_if.s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         c_if.s_logit = (i == 0) ? 8'sd127 : -8'sd128;
         tick();
      end
      c_if.s_valid = 1'b0;
      c_if.m_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         total++;
         if (c_if.m_valid !== 1'b1 || c_if.m_margin !== 8'd255 || c_if.m_class_idx !== 4'(r) || c_if.m_logit !== 8'(ev[r])) begin
            bad++;
            $display("FAIL margin_rank%0d: got v=%b margin=%0d idx=%0d logit=%0d, want v=1 margin=255 idx=%0d logit=%0d",
                     r, c_if.m_valid, c_if.m_margin, c_if.m_class_idx, c_if.m_logit, r, ev[r]);
         end
         tick();
      end
      c_if.m_ready = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      {a_if.start, a_if.s_valid, a_if.m_ready} = '0;
      a_if.s_logit = '0;
      {b_if.start, b_if.s_valid, b_if.m_ready} = '0;
      b_if.s_logit = '0;
`ifdef ARGMAX_TOPK_MARGIN_EN
      {c_if.start, c_if.s_valid, c_if.m_ready} = '0;
      c_if.s_logit = '0;
`endif
      tick();
      tick();
      test_reset();
      reset = 1'b0;
      tick();
      test_basic();
      test_most_negative();
      test_stall_gaps();
      test_reset_abort();
      test_start_ignored();
      test_topk1();
`ifdef ARGMAX_TOPK_MARGIN_EN
      test_margin();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
